timer_sched: RTL and testbench

TIMER_SCHED -- requirements
Module: timer_sched

---
 rtl/timer_sched_pkg.sv | 21 ++
 rtl/timer_sched_if.sv | 31 +++
 rtl/timer_tick_cnt.sv | 64 ++++++
 rtl/timer_sched.sv | 114 +++++++++++
 tb/tb_timer_sched.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/timer_sched_pkg.sv
// -----------------------------------------------------------------------------
// timer_sched_pkg
// Shared types and helpers for the timer scheduler:
//   state_e   - scheduler FSM states (IDLE/LOAD/RUN/FIN)
//   calc_div  - sys_clk cycles per timer tick, CLK_HZ / HZ
// -----------------------------------------------------------------------------
package timer_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    // Integer division; callers must choose CLK_HZ/HZ so the result is >= 2.
    function automatic int calc_div(input int clk_hz, input int hz);
        return clk_hz / hz;
    endfunction

endpackage

// File: rtl/timer_sched_if.sv
// -----------------------------------------------------------------------------
// timer_sched_if
// Requester-side bundle of the timer scheduler.
//   req        requester -> sched  level request, one bit per requester
//   req_ticks  requester -> sched  packed counts, requester i at [i*TW +: TW]
//   grant      sched -> requester  one-hot owner of the timer, or zero
//   done       sched -> requester  one-hot single-cycle expiry pulse
//   busy       sched -> requester  scheduler not idle
//   abort      requester -> sched  cancel running interval
//                                  (only with TIMER_SCHED_ABORT_EN defined)
// Modports: master = requester side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface timer_sched_if #(
    parameter int N_REQ = 4,
    parameter int TW    = 8
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ*TW-1:0] req_ticks;
    logic [N_REQ-1:0]    grant;
    logic [N_REQ-1:0]    done;
    logic                busy;
`ifdef TIMER_SCHED_ABORT_EN
    logic                abort;

    modport master (output req, req_ticks, abort, input grant, done, busy);
    modport slave  (input req, req_ticks, abort, output grant, done, busy);
`else
    modport master (output req, req_ticks, input grant, done, busy);
    modport slave  (input req, req_ticks, output grant, done, busy);
`endif
endinterface

// File: rtl/timer_tick_cnt.sv
// -----------------------------------------------------------------------------
// timer_tick_cnt
// Prescaler (0..DIV-1) feeding a tick_left down-counter.
//   sys_clk, sys_rst  clock, synchronous active-high reset
//   load              latch ticks (0 treated as 1), clear prescaler
//   en                count this cycle
//   abort             drop the running interval, clear both counters
//   ticks             tick count to latch on load
//   expire            high in the cycle whose edge completes the last tick
// -----------------------------------------------------------------------------
module timer_tick_cnt #(
    parameter int DIV = 10,
    parameter int TW  = 8
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          load,
    input  logic          en,
    input  logic          abort,
    input  logic [TW-1:0] ticks,
    output logic          expire
);
    localparam int PW = $clog2(DIV);

    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] tick_left_q, tick_left_d;
    logic          wrap;

    assign wrap   = en && (presc_q == PW'(DIV - 1));
    assign expire = wrap && (tick_left_q == TW'(1));

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        presc_d     = presc_q;
        tick_left_d = tick_left_q;
        if (load) begin
            presc_d     = '0;
            tick_left_d = (ticks == '0) ? TW'(1) : ticks;
        end else if (abort) begin
            presc_d     = '0;
            tick_left_d = '0;
        end else if (en) begin
            if (wrap) begin
                presc_d = '0;
                // Guarded so tick_left can never wrap below zero.
                if (tick_left_q != '0) tick_left_d = tick_left_q - TW'(1);
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            presc_q     <= '0;
            tick_left_q <= '0;
        end else begin
            presc_q     <= presc_d;
            tick_left_q <= tick_left_d;
        end
    end

endmodule

// File: rtl/timer_sched.sv
// -----------------------------------------------------------------------------
// timer_sched
// Round-robin scheduler sharing one interval timer among N_REQ requesters.
//   sys_clk   sole clock, rising edge
//   sys_rst   synchronous active-high reset
//   bus       timer_sched_if.slave: req, req_ticks in; grant, done, busy out
//             (plus abort in when TIMER_SCHED_ABORT_EN is defined)
// Optional feature macro: TIMER_SCHED_ABORT_EN (abort in LOAD/RUN -> FIN).
// The counter is loaded on the IDLE->LOAD edge and counts through LOAD and
// RUN, so FIN begins exactly T*DIV cycles after the LOAD cycle.
// -----------------------------------------------------------------------------
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int HZ     = 1000,
    parameter int N_REQ  = 4,
    parameter int TW     = 8
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    timer_sched_if.slave  bus
);
    localparam int DIV = calc_div(CLK_HZ, HZ);
    localparam int IW  = $clog2(N_REQ);

    state_e          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   winner;
    logic            pick_found;
    logic [TW-1:0]   win_ticks;
    logic            load, en, abort_act, expire;

    // Round-robin pick: lowest requesting index at or above rr_ptr, wrapping.
    always_comb begin
        winner     = rr_ptr_q;
        pick_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!pick_found && bus.req[(int'(rr_ptr_q) + k) % N_REQ]) begin
                winner     = IW'((int'(rr_ptr_q) + k) % N_REQ);
                pick_found = 1'b1;
            end
        end
        win_ticks = bus.req_ticks[int'(winner)*TW +: TW];
    end

    // req/req_ticks are only consulted in IDLE, so changes while granted
    // have no effect on the running interval.
    assign load = (state_q == ST_IDLE) && pick_found;
    assign en   = (state_q == ST_LOAD) || (state_q == ST_RUN);

`ifdef TIMER_SCHED_ABORT_EN
    assign abort_act = bus.abort && en;
`else
    assign abort_act = 1'b0;
`endif

    timer_tick_cnt #(.DIV(DIV), .TW(TW)) u_tick_cnt (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .load    (load),
        .en      (en),
        .abort   (abort_act),
        .ticks   (win_ticks),
        .expire  (expire)
    );

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_LOAD;
                    owner_d = winner;
                end
            end
            ST_LOAD: state_d = abort_act ? ST_FIN : ST_RUN;
            // Abort and final tick together still give a single FIN.
            ST_RUN:  if (expire || abort_act) state_d = ST_FIN;
            ST_FIN: begin
                state_d  = ST_IDLE;
                rr_ptr_d = IW'((int'(owner_q) + 1) % N_REQ);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state, hence one-hot by construction.
    always_comb begin
        bus.grant = '0;
        bus.done  = '0;
        bus.busy  = (state_q != ST_IDLE);
        if (state_q != ST_IDLE) bus.grant[owner_q] = 1'b1;
        if (state_q == ST_FIN)  bus.done[owner_q]  = 1'b1;
    end

endmodule

// File: tb/tb_timer_sched.sv
// -----------------------------------------------------------------------------
// tb_timer_sched
// Directed bench for timer_sched with CLK_HZ=1000, HZ=100 (DIV=10), N_REQ=4,
// TW=8. Inputs change and outputs are sampled on the falling edge.
// Abort scenario is compiled only with TIMER_SCHED_ABORT_EN.
// -----------------------------------------------------------------------------
module tb_timer_sched;

    logic sys_clk;
    logic sys_rst;
    int   total = 0;
    int   bad   = 0;

    timer_sched_if #(.N_REQ(4), .TW(8)) tif ();

    timer_sched #(
        .CLK_HZ (1000),
        .HZ     (100),
        .N_REQ  (4),
        .TW     (8)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (tif)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic set_ticks(input int i, input logic [7:0] v);
        tif.req_ticks[i*8 +: 8] = v;
    endtask

    // Called in the LOAD cycle; returns cycles until done (FIN cycle = n).
    task automatic wait_done(input int limit, output int n, output logic [3:0] d,
                             output int busy_lo);
        n = 0; d = '0; busy_lo = 0;
        while (n <= limit) begin
            @(negedge sys_clk);
            n++;
            if (!tif.busy) busy_lo++;
            if (tif.done != '0) begin
                d = tif.done;
                break;
            end
        end
    endtask

    int          n, n2, bl, w, dn;
    logic [3:0]  d;
    logic [3:0]  exp_oh;

    initial begin
        sys_rst       = 1'b1;
        tif.req       = '0;
        tif.req_ticks = '0;
`ifdef TIMER_SCHED_ABORT_EN
        tif.abort     = 1'b0;
`endif
        repeat (3) @(negedge sys_clk);
        check("rst_grant", 32'(tif.grant), 32'd0);
        check("rst_done",  32'(tif.done),  32'd0);
        check("rst_busy",  32'(tif.busy),  32'd0);
        sys_rst = 1'b0;

        // Single request, 3 ticks -> 30 cycles LOAD to FIN.
        set_ticks(0, 8'd3);
        tif.req = 4'b0001;
        @(negedge sys_clk);
        check("single_grant", 32'(tif.grant), 32'b0001);
        check("single_busy",  32'(tif.busy),  32'd1);
        wait_done(100, n, d, bl);
        check("single_lat",    32'(n),  32'd30);
        check("single_done",   32'(d),  32'b0001);
        check("single_busylo", 32'(bl), 32'd0);
        tif.req = '0;
        @(negedge sys_clk);
        check("single_done_pulse", 32'(tif.done),  32'd0);
        check("single_grant_clr",  32'(tif.grant), 32'd0);
        check("single_idle",       32'(tif.busy),  32'd0);

        // Contention from a fresh reset: order 0,1,2,3,0, 10 cycles each.
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int i = 0; i < 4; i++) set_ticks(i, 8'd1);
        tif.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_oh = 4'b0001 << (g % 4);
            w = 0;
            do begin
                @(negedge sys_clk);
                w++;
            end while (tif.grant == '0 && w < 5);
            check($sformatf("cont_grant%0d", g), 32'(tif.grant), 32'(exp_oh));
            wait_done(30, n, d, bl);
            check($sformatf("cont_lat%0d", g),  32'(n), 32'd10);
            check($sformatf("cont_done%0d", g), 32'(d), 32'(exp_oh));
            check($sformatf("cont_fin_grant%0d", g), 32'(tif.grant), 32'(exp_oh));
            if (g == 4) tif.req = '0;
            @(negedge sys_clk);
            check($sformatf("cont_gap%0d", g), 32'(tif.grant), 32'd0);
        end

        // Zero count acts as one tick (rr_ptr now 1).
        set_ticks(2, 8'd0);
        tif.req = 4'b0100;
        @(negedge sys_clk);
        check("zero_grant", 32'(tif.grant), 32'b0100);
        wait_done(50, n, d, bl);
        check("zero_lat",  32'(n), 32'd10);
        check("zero_done", 32'(d), 32'b0100);
        tif.req = '0;
        @(negedge sys_clk);
        check("zero_idle", 32'(tif.busy), 32'd0);

        // Owner drops req and rewrites ticks mid-RUN (rr_ptr now 3).
        set_ticks(0, 8'd4);
        tif.req = 4'b0001;
        @(negedge sys_clk);
        check("upd_grant", 32'(tif.grant), 32'b0001);
        repeat (5) @(negedge sys_clk);
        tif.req = 4'b1000;
        set_ticks(0, 8'd1);
        @(negedge sys_clk);
        check("upd_grant_hold", 32'(tif.grant), 32'b0001);
        wait_done(100, n2, d, bl);
        check("upd_lat",  32'(6 + n2), 32'd40);
        check("upd_done", 32'(d),      32'b0001);
        tif.req = '0;
        @(negedge sys_clk);
        check("upd_idle", 32'(tif.busy), 32'd0);

        // Reset 15 cycles into a 5-tick run (rr_ptr now 1 -> winner 2).
        set_ticks(0, 8'd5);
        set_ticks(2, 8'd5);
        tif.req = 4'b0101;
        @(negedge sys_clk);
        check("rst_run_grant", 32'(tif.grant), 32'b0100);
        dn = 0;
        repeat (15) begin
            @(negedge sys_clk);
            if (tif.done != '0) dn++;
        end
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("rst_run_grant0", 32'(tif.grant), 32'd0);
        check("rst_run_busy0",  32'(tif.busy),  32'd0);
        check("rst_run_done0",  32'(tif.done),  32'd0);
        check("rst_run_nodone", 32'(dn),        32'd0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("rst_run_rewin", 32'(tif.grant), 32'b0001);
        wait_done(100, n, d, bl);
        check("rst_run_lat",  32'(n), 32'd50);
        check("rst_run_done", 32'(d), 32'b0001);
        tif.req = '0;
        @(negedge sys_clk);

`ifdef TIMER_SCHED_ABORT_EN
        // Abort 12 cycles into a 5-tick run for requester 1 (rr_ptr now 1).
        set_ticks(1, 8'd5);
        tif.req = 4'b0010;
        @(negedge sys_clk);
        check("abort_grant", 32'(tif.grant), 32'b0010);
        repeat (12) @(negedge sys_clk);
        tif.abort = 1'b1;
        @(negedge sys_clk);
        check("abort_done", 32'(tif.done), 32'b0010);
        tif.abort = 1'b0;
        tif.req   = '0;
        @(negedge sys_clk);
        check("abort_pulse", 32'(tif.done), 32'd0);
        check("abort_idle",  32'(tif.busy), 32'd0);
        // rr_ptr advanced to 2: from {0,1} the wrap picks 0.
        set_ticks(0, 8'd1);
        set_ticks(1, 8'd1);
        tif.req = 4'b0011;
        @(negedge sys_clk);
        check("abort_rr", 32'(tif.grant), 32'b0001);
        wait_done(30, n, d, bl);
        check("abort_next_lat", 32'(n), 32'd10);
        tif.req = '0;
        @(negedge sys_clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
